// File: rtl/mod_pingpong_ctrl.sv
// Ping-pong symbol-bank controller: steers mapper writes into two banks and
// replays completed banks to the downstream consumer, oldest first.
module mod_pingpong_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int MAX_SYMBOLS = 1200
) (
    input  logic                  CLK_Mod,
    input  logic                  RST_Mod,
    input  logic                  Wr_En_In,
    input  logic [ADDR_WIDTH-1:0] Wr_Addr_In,
    input  logic                  Switch_In,
    input  logic [ADDR_WIDTH-1:0] Last_Addr_In,
    input  logic                  Rd_Ready,
    output logic                  Wea_0,
    output logic                  Wea_1,
    output logic                  Wr_Bank,
    output logic                  Wr_Hold,
    output logic                  Overflow,
    output logic                  Rd_En,
    output logic                  Rd_Bank,
    output logic [ADDR_WIDTH-1:0] Rd_Addr,
    output logic                  Rd_Data_Valid,
    output logic                  Rd_Last,
    output logic                  Frame_Start,
    output logic [ADDR_WIDTH-1:0] Frame_Len,
    output logic [1:0]            Bank_Full
);

    typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bank_st_t;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_RELEASE} rd_st_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(MAX_SYMBOLS);

    bank_st_t              bank_st  [2];
    logic [ADDR_WIDTH-1:0] bank_len [2];
    rd_st_t                rd_st;
    logic [ADDR_WIDTH-1:0] frame_len_q;
    logic [ADDR_WIDTH-1:0] clamp_len;
    logic                  other_free;
    logic                  at_last;

    // The write address goes straight to the bank RAMs; control never needs it.
    logic unused_wr_addr;
    assign unused_wr_addr = ^Wr_Addr_In;

    assign Wea_0 = Wr_En_In && !Wr_Bank && !Wr_Hold;
    assign Wea_1 = Wr_En_In &&  Wr_Bank && !Wr_Hold;

    assign Rd_En       = (rd_st == S_READ) && Rd_Ready;
    assign at_last     = (Rd_Addr == frame_len_q - 1'b1);
    assign Frame_Start = (rd_st == S_IDLE) && (bank_st[Rd_Bank] == B_FULL);
    // Show the new length already in the Frame_Start cycle.
    assign Frame_Len   = Frame_Start ? bank_len[Rd_Bank] : frame_len_q;

    assign Bank_Full[0] = (bank_st[0] != B_EMPTY);
    assign Bank_Full[1] = (bank_st[1] != B_EMPTY);

    assign clamp_len  = (Last_Addr_In > MAX_LEN) ? MAX_LEN : Last_Addr_In;
    // A bank being released this cycle is as good as empty for the toggle.
    assign other_free = (bank_st[~Wr_Bank] == B_EMPTY) ||
                        ((rd_st == S_RELEASE) && (Rd_Bank == ~Wr_Bank));

    always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
        if (!RST_Mod) begin
            bank_st[0]    <= B_EMPTY;
            bank_st[1]    <= B_EMPTY;
            bank_len[0]   <= '0;
            bank_len[1]   <= '0;
            rd_st         <= S_IDLE;
            Wr_Bank       <= 1'b0;
            Wr_Hold       <= 1'b0;
            Overflow      <= 1'b0;
            Rd_Bank       <= 1'b0;
            Rd_Addr       <= '0;
            frame_len_q   <= '0;
            Rd_Data_Valid <= 1'b0;
            Rd_Last       <= 1'b0;
        end else begin
            Rd_Data_Valid <= Rd_En;
            Rd_Last       <= Rd_En && at_last;

            if (Switch_In) begin
                if (Wr_Hold) begin
                    Overflow <= 1'b1;
                end else if (Last_Addr_In != '0) begin
                    bank_st[Wr_Bank]  <= B_FULL;
                    bank_len[Wr_Bank] <= clamp_len;
                    if (other_free) begin
                        Wr_Bank <= ~Wr_Bank;
                    end else begin
                        Wr_Hold  <= 1'b1;
                        Overflow <= 1'b1;
                    end
                end
            end

            if (Wr_Hold && (bank_st[~Wr_Bank] == B_EMPTY)) begin
                Wr_Hold <= 1'b0;
                Wr_Bank <= ~Wr_Bank;
            end

            case (rd_st)
                S_IDLE: begin
                    if (bank_st[Rd_Bank] == B_FULL) begin
                        bank_st[Rd_Bank] <= B_READING;
                        frame_len_q      <= bank_len[Rd_Bank];
                        Rd_Addr          <= '0;
                        rd_st            <= S_READ;
                    end
                end
                S_READ: begin
                    if (Rd_En) begin
                        if (at_last) rd_st   <= S_RELEASE;
                        else         Rd_Addr <= Rd_Addr + 1'b1;
                    end
                end
                S_RELEASE: begin
                    bank_st[Rd_Bank] <= B_EMPTY;
                    Rd_Bank          <= ~Rd_Bank;
                    rd_st            <= S_IDLE;
                end
                default: rd_st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_pingpong_ctrl.sv
// Directed bench for mod_pingpong_ctrl: a per-cycle vector table for one
// frame, then hand sequences for back-to-back, collision, stall, edges, reset.
module tb_mod_pingpong_ctrl;
    localparam int AW = 11;

    logic          CLK_Mod = 1'b0;
    logic          RST_Mod = 1'b0;
    logic          Wr_En_In = 1'b0;
    logic [AW-1:0] Wr_Addr_In = '0;
    logic          Switch_In = 1'b0;
    logic [AW-1:0] Last_Addr_In = '0;
    logic          Rd_Ready = 1'b0;
    logic          Wea_0, Wea_1, Wr_Bank, Wr_Hold, Overflow, Rd_En, Rd_Bank;
    logic [AW-1:0] Rd_Addr, Frame_Len;
    logic          Rd_Data_Valid, Rd_Last, Frame_Start;
    logic [1:0]    Bank_Full;

    mod_pingpong_ctrl #(.ADDR_WIDTH(AW), .MAX_SYMBOLS(1200)) dut (
        .CLK_Mod(CLK_Mod), .RST_Mod(RST_Mod), .Wr_En_In(Wr_En_In),
        .Wr_Addr_In(Wr_Addr_In), .Switch_In(Switch_In), .Last_Addr_In(Last_Addr_In),
        .Rd_Ready(Rd_Ready), .Wea_0(Wea_0), .Wea_1(Wea_1), .Wr_Bank(Wr_Bank),
        .Wr_Hold(Wr_Hold), .Overflow(Overflow), .Rd_En(Rd_En), .Rd_Bank(Rd_Bank),
        .Rd_Addr(Rd_Addr), .Rd_Data_Valid(Rd_Data_Valid), .Rd_Last(Rd_Last),
        .Frame_Start(Frame_Start), .Frame_Len(Frame_Len), .Bank_Full(Bank_Full)
    );

    always #5 CLK_Mod = ~CLK_Mod;

    // Running event totals; sequences take differences around a window.
    int dv_tot = 0, last_tot = 0, fs_tot = 0;
    always @(negedge CLK_Mod) begin
        if (Rd_Data_Valid) dv_tot   <= dv_tot + 1;
        if (Rd_Last)       last_tot <= last_tot + 1;
        if (Frame_Start)   fs_tot   <= fs_tot + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    endtask

    task automatic tick();
        @(posedge CLK_Mod);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic we, input int wa, input logic sw, input int la, input logic rdy);
        Wr_En_In     = we;
        Wr_Addr_In   = AW'(wa);
        Switch_In    = sw;
        Last_Addr_In = AW'(la);
        Rd_Ready     = rdy;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " Wr_Bank"}, Wr_Bank, 0);
        chk({tag, " Rd_Bank"}, Rd_Bank, 0);
        chk({tag, " Rd_Addr"}, Rd_Addr, 0);
        chk({tag, " Frame_Len"}, Frame_Len, 0);
        chk({tag, " Wr_Hold"}, Wr_Hold, 0);
        chk({tag, " Overflow"}, Overflow, 0);
        chk({tag, " Bank_Full"}, Bank_Full, 0);
        chk({tag, " Rd_Data_Valid"}, Rd_Data_Valid, 0);
        chk({tag, " Rd_Last"}, Rd_Last, 0);
        chk({tag, " Frame_Start"}, Frame_Start, 0);
        chk({tag, " Rd_En"}, Rd_En, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        RST_Mod = 1'b0;
        tick();
        tick();
        RST_Mod = 1'b1;
    endtask

    typedef struct {
        logic we; int wa; logic sw; int la; logic rdy;
        logic e_wea0, e_wea1, e_wrb, e_fs, e_rden;
        int   e_addr;
        logic e_dv, e_last;
        int   e_bf;
    } vec_t;

    function automatic vec_t mk(input logic we, input int wa, input logic sw, input int la,
                                input logic rdy, input logic wea0, input logic wea1,
                                input logic wrb, input logic fs, input logic rden,
                                input int addr, input logic dv, input logic lst, input int bf);
        vec_t v;
        v.we = we; v.wa = wa; v.sw = sw; v.la = la; v.rdy = rdy;
        v.e_wea0 = wea0; v.e_wea1 = wea1; v.e_wrb = wrb; v.e_fs = fs; v.e_rden = rden;
        v.e_addr = addr; v.e_dv = dv; v.e_last = lst; v.e_bf = bf;
        return v;
    endfunction

    vec_t vt [28];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt1, dv0, l0, f0, maxa, found;
        logic [5:0] stall_rdy;
        int stall_addr [6];

        // Single 12-symbol frame, one vector per cycle.
        for (int c = 0; c < 12; c++) vt[c] = mk(1, c, 0, 0, 1, 1, 0, 0, 0, 0, -1, 0, 0, 0);
        vt[12] = mk(0, 0, 1, 12, 1, 0, 0, 0, 0, 0, -1, 0, 0, 0);
        vt[13] = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, -1, 0, 0, 1);
        for (int c = 14; c < 26; c++) vt[c] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, c - 14, c >= 15, 0, 1);
        vt[26] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, -1, 1, 1, 1);
        vt[27] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, -1, 0, 0, 0);

        drive(0, 0, 0, 0, 0);
        RST_Mod = 1'b0;
        #3;
        chk_reset("reset");
        do_reset();

        for (int i = 0; i < 28; i++) begin
            drive(vt[i].we, vt[i].wa, vt[i].sw, vt[i].la, vt[i].rdy);
            settle();
            chk($sformatf("v%0d Wea_0", i), Wea_0, vt[i].e_wea0);
            chk($sformatf("v%0d Wea_1", i), Wea_1, vt[i].e_wea1);
            chk($sformatf("v%0d Wr_Bank", i), Wr_Bank, vt[i].e_wrb);
            chk($sformatf("v%0d Frame_Start", i), Frame_Start, vt[i].e_fs);
            chk($sformatf("v%0d Rd_En", i), Rd_En, vt[i].e_rden);
            chk($sformatf("v%0d Rd_Data_Valid", i), Rd_Data_Valid, vt[i].e_dv);
            chk($sformatf("v%0d Rd_Last", i), Rd_Last, vt[i].e_last);
            chk($sformatf("v%0d Bank_Full", i), Bank_Full, vt[i].e_bf);
            if (vt[i].e_addr >= 0) begin
                chk($sformatf("v%0d Rd_Addr", i), Rd_Addr, vt[i].e_addr);
                chk($sformatf("v%0d Rd_Bank", i), Rd_Bank, 0);
            end
            if (vt[i].e_fs || vt[i].e_rden) chk($sformatf("v%0d Frame_Len", i), Frame_Len, 12);
            tick();
        end

        // Back-to-back 1200-symbol frames; bank 1 completes in bank 0's RELEASE cycle.
        do_reset();
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 1200; i++) begin
            drive(1, i, 0, 0, 1); settle(); if (Wea_0) cnt0++; tick();
        end
        dv0 = dv_tot; l0 = last_tot; f0 = fs_tot;
        drive(0, 0, 1, 1200, 1); tick();
        for (int i = 0; i < 1200; i++) begin
            drive(1, i, 0, 0, 1); settle(); if (Wea_1) cnt1++; tick();
        end
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 1, 1200, 1); settle();
        chk("b2b release cycle Rd_Last", Rd_Last, 1);
        tick();
        drive(0, 0, 0, 0, 1); settle();
        chk("b2b 2nd Frame_Start", Frame_Start, 1);
        chk("b2b 2nd Rd_Bank", Rd_Bank, 1);
        chk("b2b Wr_Bank", Wr_Bank, 0);
        chk("b2b Wr_Hold", Wr_Hold, 0);
        repeat (1210) tick();
        chk("b2b Wea_0 count", cnt0, 1200);
        chk("b2b Wea_1 count", cnt1, 1200);
        chk("b2b valid count", dv_tot - dv0, 2400);
        chk("b2b last count", last_tot - l0, 2);
        chk("b2b frame starts", fs_tot - f0, 2);
        chk("b2b Overflow", Overflow, 0);
        chk("b2b Bank_Full", Bank_Full, 0);

        // Collision: both banks fill with the consumer stalled.
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, i, 0, 0, 0); tick(); end
        drive(0, 0, 1, 4, 0); tick();
        for (int i = 0; i < 4; i++) begin drive(1, i, 0, 0, 0); tick(); end
        drive(0, 0, 1, 4, 0); tick();
        drive(1, 7, 0, 0, 0); settle();
        chk("coll Wr_Hold", Wr_Hold, 1);
        chk("coll Overflow", Overflow, 1);
        chk("coll Wea_0", Wea_0, 0);
        chk("coll Wea_1", Wea_1, 0);
        chk("coll Wr_Bank", Wr_Bank, 1);
        chk("coll Bank_Full", Bank_Full, 3);
        tick();
        drive(0, 0, 1, 4, 0); tick();
        drive(0, 0, 0, 0, 0); settle();
        chk("coll 3rd Wr_Bank", Wr_Bank, 1);
        chk("coll 3rd Wr_Hold", Wr_Hold, 1);
        chk("coll 3rd Bank_Full", Bank_Full, 3);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 1); settle();
            if (!Bank_Full[0]) begin found = 1; break; end
            tick();
        end
        chk("coll bank0 drained", found, 1);
        chk("coll hold same cycle", Wr_Hold, 1);
        tick(); settle();
        chk("coll hold cleared", Wr_Hold, 0);
        chk("coll Wr_Bank back", Wr_Bank, 0);
        chk("coll Overflow sticky", Overflow, 1);

        // Stall: Rd_Ready 1,0,0,1 then high through a 4-symbol read.
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, i, 0, 0, 0); tick(); end
        drive(0, 0, 1, 4, 0); tick();
        drive(0, 0, 0, 0, 0); settle();
        chk("stall Frame_Start", Frame_Start, 1);
        dv0 = dv_tot; l0 = last_tot;
        tick();
        stall_rdy = 6'b111001;
        stall_addr = '{0, 1, 1, 1, 2, 3};
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, stall_rdy[k]); settle();
            chk($sformatf("stall %0d Rd_Addr", k), Rd_Addr, stall_addr[k]);
            chk($sformatf("stall %0d Rd_En", k), Rd_En, stall_rdy[k]);
            tick();
        end
        drive(0, 0, 0, 0, 1); tick(); tick();
        chk("stall valid count", dv_tot - dv0, 4);
        chk("stall last count", last_tot - l0, 1);

        // Edge cases: zero-length switch ignored, oversize length clamped.
        do_reset();
        drive(0, 0, 1, 0, 1); tick();
        drive(0, 0, 0, 0, 1); settle();
        chk("zero Wr_Bank", Wr_Bank, 0);
        chk("zero Bank_Full", Bank_Full, 0);
        chk("zero Frame_Start", Frame_Start, 0);
        chk("zero Overflow", Overflow, 0);
        tick();
        dv0 = dv_tot;
        drive(0, 0, 1, 1500, 1); tick();
        drive(0, 0, 0, 0, 1); settle();
        chk("clamp Frame_Start", Frame_Start, 1);
        chk("clamp Frame_Len", Frame_Len, 1200);
        chk("clamp Wr_Bank", Wr_Bank, 1);
        tick(); settle();
        chk("clamp Frame_Len held", Frame_Len, 1200);
        maxa = 0;
        for (int k = 0; k < 1205; k++) begin
            settle();
            if (Rd_En && int'(Rd_Addr) > maxa) maxa = int'(Rd_Addr);
            tick();
        end
        chk("clamp max Rd_Addr", maxa, 1199);
        chk("clamp valid count", dv_tot - dv0, 1200);

        // Reset asserted mid-read at Rd_Addr 5.
        do_reset();
        for (int i = 0; i < 8; i++) begin drive(1, i, 0, 0, 1); tick(); end
        drive(0, 0, 1, 8, 1); tick();
        drive(0, 0, 0, 0, 1);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (Rd_En && Rd_Addr == 5) begin found = 1; break; end
            tick();
        end
        chk("rst reached addr 5", found, 1);
        l0 = last_tot;
        drive(0, 0, 0, 0, 0);
        #2;
        RST_Mod = 1'b0;
        #1;
        chk_reset("midrst");
        tick(); tick();
        RST_Mod = 1'b1;
        chk("midrst no Rd_Last", last_tot - l0, 0);
        drive(1, 0, 0, 0, 1); settle();
        chk("midrst Wea_0", Wea_0, 1);
        tick();
        drive(1, 1, 0, 0, 1); tick();
        drive(0, 0, 1, 2, 1); tick();
        drive(0, 0, 0, 0, 1); settle();
        chk("midrst Frame_Start", Frame_Start, 1);
        chk("midrst Rd_Bank", Rd_Bank, 0);
        chk("midrst Frame_Len", Frame_Len, 2);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mod_pingpong_ctrl.md
# mod_pingpong_ctrl

Ping-pong buffer controller between the modulation mapper and the downstream consumer (resource-element mapper / transform precoder). It steers mapper writes into one of two symbol banks, tracks each bank's fill length and state, and sequences reads of completed banks to the consumer under a ready handshake. Full-bank collisions are handled by holding the write side.

## Interface
- ADDR_WIDTH, 11, bank address width.
- MAX_SYMBOLS, 1200, bank depth in symbols.
- CLK_Mod  in  1  clock.
- RST_Mod  in  1  reset; asynchronous, active-low.
- Wr_En_In  in  1  mapper write strobe (mapper write_enable).
- Wr_Addr_In  in  ADDR_WIDTH  mapper write address, used unmodified as bank address.
- Switch_In  in  1  one-cycle bank-complete pulse (mapper PINGPONG_SWITCH).
- Last_Addr_In  in  ADDR_WIDTH  symbol count of the completed bank, valid with Switch_In.
- Rd_Ready  in  1  consumer accepts one symbol per cycle.
- Wea_0, Wea_1  out  1  per-bank write enables.
- Wr_Bank  out  1  bank currently written.
- Wr_Hold  out  1  writes gated; both banks occupied.
- Overflow  out  1  sticky; a bank completed while the other bank was not EMPTY.
- Rd_En  out  1  bank read strobe.
- Rd_Bank  out  1  bank being read.
- Rd_Addr  out  ADDR_WIDTH  read address.
- Rd_Data_Valid  out  1  read data valid, Rd_En delayed 1 cycle.
- Rd_Last  out  1  aligned with Rd_Data_Valid on the bank's final symbol.
- Frame_Start  out  1  one-cycle pulse when a bank read begins.
- Frame_Len  out  ADDR_WIDTH  length of the bank being read; held until the next Frame_Start.
- Bank_Full  out  2  bit b is set when bank b is FULL or READING.

## Operation
- Per-bank state is EMPTY, FULL or READING. Per-bank length register holds ADDR_WIDTH bits.
- Write side:
  - Wea_b = Wr_En_In & (Wr_Bank==b) & !Wr_Hold (combinational).
  - A write arriving in the same cycle as Switch_In goes to the current Wr_Bank.
- On Switch_In with Last_Addr_In != 0:
  - Current bank becomes FULL; its length is set to Last_Addr_In, clamped to MAX_SYMBOLS.
  - If the other bank is EMPTY, or is being released this cycle, Wr_Bank toggles.
  - Otherwise Wr_Bank stays, Wr_Hold sets and Overflow sets.
- Switch_In with Last_Addr_In == 0 is ignored.
- Switch_In while Wr_Hold is set is ignored; Overflow sets.
- Wr_Hold clears, and Wr_Bank toggles, in the cycle after the other bank returns to EMPTY.
- Read FSM:
  - IDLE: if bank Rd_Bank is FULL, it becomes READING; Frame_Start pulses; Frame_Len is loaded; Rd_Addr is set to 0; go to READ.
  - READ: Rd_En = Rd_Ready (combinational). Each Rd_En increments Rd_Addr. On Rd_En with Rd_Addr == length-1, go to RELEASE.
  - RELEASE (1 cycle): bank Rd_Bank becomes EMPTY; Rd_Bank toggles; go to IDLE.
- Reads therefore alternate banks strictly, oldest first.
- Overflow clears only on reset.

## Timing
- Reset values: state IDLE; both banks EMPTY with length 0. All outputs are 0: Wr_Bank, Rd_Bank, Rd_Addr, Frame_Len, Wr_Hold, Overflow, Bank_Full, Rd_Data_Valid, Rd_Last, Frame_Start.
- Reset mid-frame discards both banks immediately; no partial Rd_Last is issued.
- Switch_In cycle N:
  - Bank FULL and Wr_Bank toggled at edge N+1.
  - Earliest Frame_Start is in cycle N+1; earliest Rd_En is in cycle N+2.
- Rd_Data_Valid and Rd_Last are registered versions of Rd_En and the last-address condition, 1 cycle later.
- Minimum bank turnaround: length + 2 cycles (Frame_Start/IDLE cycle plus RELEASE).
- Rd_Ready low in READ freezes Rd_Addr; there is no timeout.
- Simultaneous Switch_In and RELEASE of the other bank: the toggle is permitted; no Wr_Hold, no Overflow.
- Rd_Addr never exceeds length-1, and Rd_Addr never exceeds MAX_SYMBOLS-1.

## Test plan
- Single frame:
  - Stimulus: write addresses 0..11, then Switch_In with Last_Addr_In=12, Rd_Ready=1.
  - Required: Wea_0 on all 12 writes. Wr_Bank=1 next cycle. Frame_Start with Frame_Len=12. Rd_Addr 0..11 on bank 0. Rd_Last on the 12th Rd_Data_Valid. Bank_Full returns to 00.
- Back-to-back frames:
  - Stimulus: two 1200-symbol frames, Rd_Ready=1.
  - Required: banks alternate 0,1. The second frame's Frame_Start follows the first frame's RELEASE. No Overflow.
- Collision:
  - Stimulus: fill bank 0 and bank 1 while Rd_Ready=0, then complete a third frame.
  - Required: Wr_Hold=1, Overflow=1, Wea_0 and Wea_1 stay 0. After bank 0 drains, Wr_Hold clears one cycle later and Wr_Bank=0. Overflow stays 1.
- Stall:
  - Stimulus: toggle Rd_Ready 1,0,0,1 during a 4-symbol read.
  - Required: Rd_Addr holds during the low cycles. Exactly 4 Rd_Data_Valid pulses. One Rd_Last.
- Edge cases:
  - Stimulus: Switch_In with Last_Addr_In=0; Last_Addr_In=1500.
  - Required: the 0 case is ignored with state unchanged. The 1500 case gives Frame_Len=1200.
- Reset mid-read:
  - Stimulus: assert RST_Mod at Rd_Addr=5.
  - Required: all outputs return to reset values asynchronously. No Rd_Last. Next frame starts on bank 0.
